// File: rtl/rv32_mem_stage_if.sv
// Handshake and data-bus bundle between execute, the memory stage and the data bus.
// slave is the memory stage's view; master is the view of its surroundings.
interface rv32_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_read;
  logic        in_write;
  logic [1:0]  in_width;
  logic        in_zero_extend;
  logic [4:0]  in_rd;
  logic        in_rd_write;
  logic [31:0] in_result;
  logic [31:0] in_rs2_value;

  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_write_mask;
  logic [31:0] data_write_value;
  logic [31:0] data_read_value;
  logic        data_ready;

  logic        out_valid;
  logic [4:0]  out_rd;
  logic        out_rd_write;
  logic [31:0] out_rd_value;
  logic        out_fault;

  modport slave (
    input  in_valid, in_read, in_write, in_width, in_zero_extend,
    input  in_rd, in_rd_write, in_result, in_rs2_value,
    output in_ready,
    output data_address, data_read, data_write, data_write_mask, data_write_value,
    input  data_read_value, data_ready,
    output out_valid, out_rd, out_rd_write, out_rd_value, out_fault
  );

  modport master (
    output in_valid, in_read, in_write, in_width, in_zero_extend,
    output in_rd, in_rd_write, in_result, in_rs2_value,
    input  in_ready,
    input  data_address, data_read, data_write, data_write_mask, data_write_value,
    output data_read_value, data_ready,
    input  out_valid, out_rd, out_rd_write, out_rd_value, out_fault
  );
endinterface

// File: rtl/rv32_mem_stage.sv
// RV32 memory stage: pass-through ALU results, issue aligned loads/stores on the data bus, fault misaligned/illegal ops.
// Latency 1 for pass-through/faults, 2+ for bus ops; in_ready low while a bus access or its wait is outstanding.
module rv32_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  rv32_mem_stage_if.slave  mem
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LAST_WAIT  = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      state, state_next;
  logic [31:0] wait_cnt;

  // Op fields held for the duration of a bus access
  logic        op_read;
  logic [1:0]  op_lo;
  logic [1:0]  op_width;
  logic        op_zext;
  logic [4:0]  op_rd;
  logic        op_rd_write;

  logic        accept, is_mem, misaligned, illegal, go_bus, timeout_hit;
  logic [3:0]  store_mask;
  logic [31:0] store_value;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  assign mem.in_ready = (state == IDLE);

  always_comb begin
    accept     = mem.in_valid && (state == IDLE);
    is_mem     = mem.in_read || mem.in_write;
    misaligned = ((mem.in_width == 2'b01) && mem.in_result[0]) ||
                 ((mem.in_width == 2'b10) && (mem.in_result[1:0] != 2'b00));
    illegal    = is_mem && ((mem.in_read && mem.in_write) || (mem.in_width == 2'b11) || misaligned);
    go_bus     = accept && is_mem && !illegal;
    // A ready in the final allowed cycle takes priority over the abort
    timeout_hit = TIMEOUT_EN && (state == BUS) && !mem.data_ready && (wait_cnt == LAST_WAIT);
  end

  always_comb begin
    store_mask  = 4'b1111;
    store_value = mem.in_rs2_value;
    case (mem.in_width)
      2'b00: begin
        store_mask  = 4'b0001 << mem.in_result[1:0];
        store_value = {4{mem.in_rs2_value[7:0]}};
      end
      2'b01: begin
        store_mask  = 4'b0011 << mem.in_result[1:0];
        store_value = {2{mem.in_rs2_value[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = mem.data_read_value[7:0];
    case (op_lo)
      2'd1:    load_byte = mem.data_read_value[15:8];
      2'd2:    load_byte = mem.data_read_value[23:16];
      2'd3:    load_byte = mem.data_read_value[31:24];
      default: ;
    endcase
    load_half  = op_lo[1] ? mem.data_read_value[31:16] : mem.data_read_value[15:0];
    load_value = mem.data_read_value;
    if (op_width == 2'b00)
      load_value = op_zext ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
    else if (op_width == 2'b01)
      load_value = op_zext ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (go_bus) state_next = BUS;
    end else if (mem.data_ready || timeout_hit) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt             <= 32'd0;
      op_read              <= 1'b0;
      op_lo                <= 2'd0;
      op_width             <= 2'd0;
      op_zext              <= 1'b0;
      op_rd                <= 5'd0;
      op_rd_write          <= 1'b0;
      mem.data_address     <= 32'd0;
      mem.data_read        <= 1'b0;
      mem.data_write       <= 1'b0;
      mem.data_write_mask  <= 4'd0;
      mem.data_write_value <= 32'd0;
      mem.out_valid        <= 1'b0;
      mem.out_rd           <= 5'd0;
      mem.out_rd_write     <= 1'b0;
      mem.out_rd_value     <= 32'd0;
      mem.out_fault        <= 1'b0;
    end else begin
      mem.out_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (illegal) begin
            mem.out_valid    <= 1'b1;
            mem.out_fault    <= 1'b1;
            mem.out_rd       <= mem.in_rd;
            mem.out_rd_write <= 1'b0;
            mem.out_rd_value <= 32'd0;
          end else if (!is_mem) begin
            mem.out_valid    <= 1'b1;
            mem.out_fault    <= 1'b0;
            mem.out_rd       <= mem.in_rd;
            mem.out_rd_write <= mem.in_rd_write;
            mem.out_rd_value <= mem.in_result;
          end else begin
            wait_cnt             <= 32'd0;
            op_read              <= mem.in_read;
            op_lo                <= mem.in_result[1:0];
            op_width             <= mem.in_width;
            op_zext              <= mem.in_zero_extend;
            op_rd                <= mem.in_rd;
            op_rd_write          <= mem.in_rd_write;
            mem.data_address     <= {mem.in_result[31:2], 2'b00};
            mem.data_read        <= mem.in_read;
            mem.data_write       <= mem.in_write;
            mem.data_write_mask  <= mem.in_write ? store_mask  : 4'd0;
            mem.data_write_value <= mem.in_write ? store_value : 32'd0;
          end
        end
      end else if (mem.data_ready) begin
        mem.data_read    <= 1'b0;
        mem.data_write   <= 1'b0;
        mem.out_valid    <= 1'b1;
        mem.out_fault    <= 1'b0;
        mem.out_rd       <= op_rd;
        mem.out_rd_write <= op_read && op_rd_write;
        mem.out_rd_value <= op_read ? load_value : 32'd0;
      end else if (timeout_hit) begin
        mem.data_read    <= 1'b0;
        mem.data_write   <= 1'b0;
        mem.out_valid    <= 1'b1;
        mem.out_fault    <= 1'b1;
        mem.out_rd       <= op_rd;
        mem.out_rd_write <= 1'b0;
        mem.out_rd_value <= 32'd0;
      end else begin
        wait_cnt <= wait_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Scoreboard bench for rv32_mem_stage: directed cases then randomized ops against an arithmetic reference model.
module tb_rv32_mem_stage;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rv32_mem_stage_if bus ();
  rv32_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .mem(bus));

  typedef struct {
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] value;
    logic        fault;
    bit          check_rd;
    bit          check_val;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          is_read;
    logic [3:0]  mask;
    logic [31:0] wvalue;
    int          waits;
    logic [31:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: expected writeback and bus transaction for one op
  task automatic issue(input bit rd_, input bit wr, input logic [1:0] w, input bit zx,
                       input logic [4:0] rd, input bit rdw, input logic [31:0] res,
                       input logic [31:0] rs2, input int waits, input logic [31:0] rdata);
    exp_t  e;
    plan_t p;
    int    a, nbytes;
    bit    bad;
    logic [63:0] m;
    logic [31:0] v;
    a = int'(res[1:0]);
    nbytes = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    bad = (rd_ || wr) && ((rd_ && wr) || w == 2'd3 || (w == 2'd1 && a % 2 != 0) || (w == 2'd2 && a != 0));
    e.rd = rd; e.check_rd = 1'b0; e.check_val = 1'b1;
    if (!rd_ && !wr) begin
      e.rd_write = rdw; e.value = res; e.fault = 1'b0; e.check_rd = 1'b1;
    end else if (bad || waits >= TMO) begin
      e.rd_write = 1'b0; e.value = 32'd0; e.fault = 1'b1; e.check_val = 1'b0;
    end else if (wr) begin
      e.rd_write = 1'b0; e.value = 32'd0; e.fault = 1'b0;
    end else begin
      if (nbytes == 4) v = rdata;
      else begin
        m = (64'd1 << (8 * nbytes)) - 64'd1;
        v = 32'(({32'd0, rdata} >> (8 * a)) & m);
        if (!zx && v[8 * nbytes - 1]) v = v | ~32'(m);
      end
      e.rd_write = rdw; e.value = v; e.fault = 1'b0; e.check_rd = 1'b1;
    end
    if ((rd_ || wr) && !bad) begin
      p.addr = res & 32'hFFFF_FFFC;
      p.is_read = rd_;
      p.mask = 4'((32'((1 << nbytes) - 1)) << a);
      p.wvalue = (nbytes == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
                 (nbytes == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;
      p.waits = waits;
      p.rdata = rdata;
      plan_q.push_back(p);
    end
    exp_q.push_back(e);
    for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clk);
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_read = rd_; bus.in_write = wr; bus.in_width = w;
    bus.in_zero_extend = zx; bus.in_rd = rd; bus.in_rd_write = rdw;
    bus.in_result = res; bus.in_rs2_value = rs2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_read = $urandom_range(0, 1); bus.in_write = $urandom_range(0, 1);
    bus.in_result = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_fault"}, 32'(bus.out_fault), 32'd0);
    check({tag, "_out_rd_write"}, 32'(bus.out_rd_write), 32'd0);
    check({tag, "_out_rd"}, 32'(bus.out_rd), 32'd0);
    check({tag, "_out_rd_value"}, bus.out_rd_value, 32'd0);
    check({tag, "_data_req"}, {30'd0, bus.data_read, bus.data_write}, 32'd0);
    check({tag, "_data_mask"}, 32'(bus.data_write_mask), 32'd0);
    check({tag, "_data_address"}, bus.data_address, 32'd0);
    check({tag, "_data_wvalue"}, bus.data_write_value, 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid) begin
        check("req_dropped_on_done", {30'd0, bus.data_read, bus.data_write}, 32'd0);
        if (exp_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("out_fault", 32'(bus.out_fault), 32'(e.fault));
          check("out_rd_write", 32'(bus.out_rd_write), 32'(e.rd_write));
          if (e.check_rd) check("out_rd", 32'(bus.out_rd), 32'(e.rd));
          if (e.check_val) check("out_rd_value", bus.out_rd_value, e.value);
        end
      end
    end
  end

  // Bus responder: follows the planned wait count for each access, random noise otherwise
  initial begin
    plan_t cur;
    bit active = 1'b0;
    int k = 0;
    bus.data_ready = 1'b0;
    bus.data_read_value = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0; k = 0; bus.data_ready = 1'b0;
      end else if (bus.data_read || bus.data_write) begin
        if (!active) begin
          active = 1'b1; k = 0;
          if (plan_q.size() == 0) begin
            check("unexpected_bus_request", 32'd1, 32'd0);
            cur.waits = 1000; cur.is_read = bus.data_read; cur.rdata = 32'd0;
          end else begin
            cur = plan_q.pop_front();
            check("data_address", bus.data_address, cur.addr);
            check("data_read", 32'(bus.data_read), 32'(cur.is_read));
            check("data_write", 32'(bus.data_write), 32'(!cur.is_read));
            if (!cur.is_read) begin
              check("data_write_mask", 32'(bus.data_write_mask), 32'(cur.mask));
              check("data_write_value", bus.data_write_value, cur.wvalue);
            end
          end
        end
        k++;
        if (bus.in_ready) check("in_ready_during_bus", 32'(bus.in_ready), 32'd0);
        if (k > TMO + 1) check("bus_cycle_overrun", 32'(k), 32'(TMO));
        bus.data_ready = (k == cur.waits + 1);
        bus.data_read_value = bus.data_ready ? cur.rdata : $urandom;
      end else begin
        if (active) check("bus_cycles", 32'(k), 32'((cur.waits >= TMO) ? TMO : cur.waits + 1));
        active = 1'b0;
        bus.data_ready = 1'($urandom_range(0, 1));
        bus.data_read_value = $urandom;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_read = 1'b0; bus.in_write = 1'b0; bus.in_width = 2'd0;
    bus.in_zero_extend = 1'b0; bus.in_rd = 5'd0; bus.in_rd_write = 1'b0;
    bus.in_result = 32'd0; bus.in_rs2_value = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    issue(0, 0, 2'd2, 0, 5'd5, 1, 32'h1234_5678, 32'd0, 0, 32'd0);
    issue(1, 0, 2'd0, 0, 5'd7, 1, 32'h0000_0103, 32'd0, 3, 32'h80FF_FFFF);
    issue(0, 1, 2'd1, 0, 5'd8, 1, 32'h0000_0202, 32'hAABB_CCDD, 0, 32'd0);
    issue(1, 0, 2'd2, 0, 5'd9, 1, 32'h0000_0101, 32'd0, 0, 32'd0);
    issue(1, 0, 2'd2, 0, 5'd10, 1, 32'h0000_0200, 32'd0, 1000, 32'd0);
    issue(1, 0, 2'd2, 0, 5'd11, 1, 32'h0000_0204, 32'd0, TMO - 1, 32'hCAFE_F00D);
    issue(0, 1, 2'd2, 0, 5'd12, 0, 32'h0000_0300, 32'h1122_3344, TMO, 32'd0);
    issue(1, 1, 2'd2, 0, 5'd13, 1, 32'h0000_0400, 32'd0, 0, 32'd0);
    issue(1, 0, 2'd3, 1, 5'd14, 1, 32'h0000_0400, 32'd0, 0, 32'd0);
    issue(1, 0, 2'd1, 1, 5'd15, 1, 32'h0000_0502, 32'd0, 0, 32'h8765_4321);
    drain();

    // Reset in the middle of a bus wait abandons the access silently
    issue(1, 0, 2'd2, 0, 5'd16, 1, 32'h0000_0600, 32'd0, 1000, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs("midbus_reset");
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [31:0] rdata, rs2, res;
      kind = $urandom_range(0, 7);
      rdata = $urandom; rs2 = $urandom;
      res = 32'h0000_1000 + 32'($urandom_range(0, 255));
      if (kind <= 1)
        issue(0, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
              $urandom, rs2, 0, rdata);
      else
        issue(kind <= 4 || kind == 7, kind >= 5, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom), 1'($urandom_range(0, 1)), res, rs2, $urandom_range(0, TMO + 1), rdata);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
